out_display_driver: RTL

- Consumes the CPU's 8-bit `out` register and drives a 4-digit multiplexed common-anode seven-segment display.
- A sequential double-dabble converter turns the value into decimal digits, unsigned or two's-complement signed.
- A prescaled scan counter time-multiplexes the four digits.
- Sits beside the cpu at the top level, with `value` wired directly to cpu.out.

---
 rtl/out_display_driver.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/out_display_driver.sv
// 8-bit value to 4-digit multiplexed seven-segment driver.
// Sequential double-dabble conversion, unsigned or signed.
module out_display_driver #(
  parameter int DIV_WIDTH   = 16,
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       signed_mode,
  output logic       busy,
  output logic       negative,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [3:0] an,
  output logic [6:0] seg
);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LOAD
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [DIV_WIDTH-1:0] PRE_LAST =
    DIV_WIDTH'(REFRESH_DIV - 1);

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            neg_q, neg_d;
  logic            pend_q, pend_d;
  logic [3:0]      hun_q, hun_d;
  logic [3:0]      ten_q, ten_d;
  logic [3:0]      one_q, one_d;
  logic [7:0]      lval_q, lval_d;
  logic            lmode_q, lmode_d;
  logic [19:0]     sh_q, sh_d;
  logic [2:0]      iter_q, iter_d;
  logic [DIV_WIDTH-1:0] pre_q, pre_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  logic [7:0]      mag;
  logic [19:0]     adj;
  logic            wrap;

  function automatic logic [3:0] add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // 8'h80 negates to 8'h80, which reads as 128 unsigned.
  assign mag = (signed_mode && value[7]) ?
               (~value + 8'd1) : value;

  assign adj = {add3(sh_q[19:16]),
                add3(sh_q[15:12]),
                add3(sh_q[11:8]),
                sh_q[7:0]};

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    neg_d   = neg_q;
    pend_d  = pend_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    one_d   = one_q;
    lval_d  = lval_q;
    lmode_d = lmode_q;
    sh_d    = sh_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (value != lval_q ||
            signed_mode != lmode_q) begin
          lval_d  = value;
          lmode_d = signed_mode;
          pend_d  = signed_mode & value[7];
          sh_d    = {12'b0, mag};
          iter_d  = 3'd0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        sh_d   = {adj[18:0], 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        hun_d   = sh_q[19:16];
        ten_d   = sh_q[15:12];
        one_d   = sh_q[11:8];
        neg_d   = pend_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign wrap = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = wrap ? '0 : pre_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    unique case (1'b1)
      (idx_q == 2'd0): begin
        an_d  = 4'b1110;
        seg_d = seg7(one_q);
      end
      (idx_q == 2'd1): begin
        an_d = 4'b1101;
        if (hun_q != 4'd0 || ten_q != 4'd0) begin
          seg_d = seg7(ten_q);
        end
      end
      (idx_q == 2'd2): begin
        an_d = 4'b1011;
        if (hun_q != 4'd0) begin
          seg_d = seg7(hun_q);
        end
      end
      (idx_q == 2'd3): begin
        an_d = 4'b0111;
        if (neg_q) begin
          seg_d = SEG_MINUS;
        end
      end
      default: begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      neg_q   <= 1'b0;
      pend_q  <= 1'b0;
      hun_q   <= 4'd0;
      ten_q   <= 4'd0;
      one_q   <= 4'd0;
      lval_q  <= 8'd0;
      lmode_q <= 1'b0;
      sh_q    <= 20'd0;
      iter_q  <= 3'd0;
      pre_q   <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      neg_q   <= neg_d;
      pend_q  <= pend_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
      lval_q  <= lval_d;
      lmode_q <= lmode_d;
      sh_q    <= sh_d;
      iter_q  <= iter_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign busy         = busy_q;
  assign negative     = neg_q;
  assign bcd_hundreds = hun_q;
  assign bcd_tens     = ten_q;
  assign bcd_ones     = one_q;
  assign an           = an_q;
  assign seg          = seg_q;

endmodule
